sprite_writer: RTL and testbench

Host-side loader that fills the sprite pixel memories, which the sprite renderer reads as 32x32, 4-bit colour-code ROMs.
- Software pushes a sprite index, then 128 packed 32-bit words (8 pixels per word) over a valid/ready stream.
- The block unpacks each word into one 4-bit write per cycle on a RAM write port, in row-major order: address = (line<<5) + pixel.
- It sits between the Avalon register slave and the write port of the dual-port sprite RAMs, which replace the init-file ROMs.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_writer_if.sv | 23 ++
 rtl/sprite_ram_dp.sv | 20 ++
 rtl/sprite_writer.sv | 96 +++++++++
 tb/tb_sprite_writer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite geometry and writer state encoding; also imported by the sprite renderer.
package sprite_pkg;

  localparam int unsigned SPR_IDW      = 6;
  localparam int unsigned SPR_ADDRW    = 10;
  localparam int unsigned PIX_W        = 4;
  localparam int unsigned PIX_PER_WORD = 8;
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int unsigned NIB_W        = $clog2(PIX_PER_WORD);
  localparam int unsigned SPR_DEPTH    = 1 << SPR_ADDRW;

  localparam logic [SPR_IDW-1:0] SPR_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    UNPACK,
    DONE
  } wr_state_e;

endpackage

// File: rtl/sprite_writer_if.sv
// Host-side command/data stream into the sprite writer.
interface sprite_writer_if;
  import sprite_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SPR_IDW-1:0]   cmd_sprite;
  logic                 data_valid;
  logic                 data_ready;
  logic [WORD_W-1:0]    data_word;
  logic                 abort;

  modport master (
    output cmd_valid, cmd_sprite, data_valid, data_word, abort,
    input  cmd_ready, data_ready
  );

  modport slave (
    input  cmd_valid, cmd_sprite, data_valid, data_word, abort,
    output cmd_ready, data_ready
  );

endinterface

// File: rtl/sprite_ram_dp.sv
// Simple dual-port sprite pixel RAM: write port from the loader, registered 1-cycle read port.
module sprite_ram_dp
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [SPR_ADDRW-1:0] waddr,
  input  logic [PIX_W-1:0]     wdata,
  input  logic [SPR_ADDRW-1:0] raddr,
  output logic [PIX_W-1:0]     rdata
);

  logic [PIX_W-1:0] mem [SPR_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_writer.sv
// Unpacks host words of 8 packed pixels into one 4-bit sprite RAM write per cycle.
module sprite_writer
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sprite_writer_if.slave       host,
  output logic                 wr_en,
  output logic [SPR_IDW-1:0]   wr_sprite,
  output logic [SPR_ADDRW-1:0] wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(PIX_PER_WORD - 1);

  wr_state_e            state;
  logic [SPR_ADDRW-1:0] cnt;
  logic [WORD_W-1:0]    shift;
  logic [NIB_W-1:0]     nib;

  assign host.cmd_ready  = (state == IDLE);
  assign host.data_ready = (state == WAIT_WORD);

  // cnt always points one past the address on wr_addr, so cnt==0 while showing nibble 7 means 1023 was the last pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      nib       <= '0;
      wr_en     <= 1'b0;
      wr_sprite <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      if (state != IDLE && host.abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (host.cmd_valid) begin
              if (host.cmd_sprite != SPR_NONE) begin
                wr_sprite <= host.cmd_sprite;
                cnt       <= '0;
                busy      <= 1'b1;
                state     <= WAIT_WORD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          WAIT_WORD: begin
            if (host.data_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= cnt;
              wr_data <= host.data_word[PIX_W-1:0];
              shift   <= host.data_word >> PIX_W;
              cnt     <= cnt + SPR_ADDRW'(1);
              nib     <= '0;
              state   <= UNPACK;
            end
          end
          UNPACK: begin
            if (nib == NIB_LAST) begin
              done  <= (cnt == '0);
              state <= (cnt == '0) ? DONE : WAIT_WORD;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= cnt;
              wr_data <= shift[PIX_W-1:0];
              shift   <= shift >> PIX_W;
              cnt     <= cnt + SPR_ADDRW'(1);
              nib     <= nib + NIB_W'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_writer.sv
// Directed bench for sprite_writer with a write scoreboard and one sprite RAM on the write port.
module tb_sprite_writer;
  import sprite_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 wr_en;
  logic [SPR_IDW-1:0]   wr_sprite;
  logic [SPR_ADDRW-1:0] wr_addr;
  logic [PIX_W-1:0]     wr_data;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [SPR_ADDRW-1:0] raddr;
  logic [PIX_W-1:0]     rdata;
  logic                 ram_we;

  sprite_writer_if hif ();

  sprite_writer dut (
    .clk       (clk),
    .reset     (reset),
    .host      (hif.slave),
    .wr_en     (wr_en),
    .wr_sprite (wr_sprite),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign ram_we = wr_en && (wr_sprite == SPR_IDW'(29));

  sprite_ram_dp ram29 (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncheck = 0;
  int npass  = 0;
  int nfail  = 0;

  // Scoreboard of writes seen on the RAM port
  int                 nwrites, ndup, ndone, nbad;
  bit                 seen    [SPR_DEPTH];
  logic [PIX_W-1:0]   model   [SPR_DEPTH];
  logic [SPR_ADDRW-1:0] last_addr;
  logic [PIX_W-1:0]   last_data;

  always @(posedge clk) begin
    if (wr_en) begin
      if (seen[wr_addr]) ndup++;
      seen[wr_addr]  = 1'b1;
      model[wr_addr] = wr_data;
      last_addr      = wr_addr;
      last_data      = wr_data;
      nwrites++;
      if (hif.data_ready) nbad++;
    end
    if (done) ndone++;
  end

  task automatic clear_model();
    nwrites = 0; ndup = 0; ndone = 0; nbad = 0;
    for (int i = 0; i < int'(SPR_DEPTH); i++) begin
      seen[i]  = 1'b0;
      model[i] = '0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [SPR_IDW-1:0] id);
    hif.cmd_valid  = 1'b1;
    hif.cmd_sprite = id;
    tick();
    hif.cmd_valid  = 1'b0;
  endtask

  // Leaves the bench in the first UNPACK cycle (nibble 0 on the write port).
  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) tick();
    n = 0;
    while (!hif.data_ready && n < 40) begin
      tick();
      n++;
    end
    check("data_ready_wait", 32'(hif.data_ready), 32'd1);
    hif.data_valid = 1'b1;
    hif.data_word  = w;
    tick();
    hif.data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("done_wait", 32'(done), 32'd1);
  endtask

  initial begin
    int bad;
    reset          = 1'b1;
    hif.cmd_valid  = 1'b0;
    hif.cmd_sprite = '0;
    hif.data_valid = 1'b0;
    hif.data_word  = '0;
    hif.abort      = 1'b0;
    raddr          = '0;
    clear_model();

    // Reset then idle
    tick(); tick();
    reset = 1'b0;
    check("rst_cmd_ready",  32'(hif.cmd_ready), 32'd1);
    check("rst_data_ready", 32'(hif.data_ready), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_wr_en",      32'(wr_en), 32'd0);
    check("rst_done",       32'(done), 32'd0);
    check("rst_err",        32'(err), 32'd0);
    check("rst_wr_sprite",  32'(wr_sprite), 32'd0);
    check("rst_wr_addr",    32'(wr_addr), 32'd0);
    check("rst_wr_data",    32'(wr_data), 32'd0);
    tick();

    // Single word to sprite 28
    send_cmd(SPR_IDW'(28));
    check("cmd_busy",       32'(busy), 32'd1);
    check("cmd_data_ready", 32'(hif.data_ready), 32'd1);
    check("cmd_wr_sprite",  32'(wr_sprite), 32'd28);
    send_word(32'h7654_3210, 0);
    for (int k = 0; k < 8; k++) begin
      check("sw_wr_en",      32'(wr_en), 32'd1);
      check("sw_wr_addr",    32'(wr_addr), 32'(k));
      check("sw_wr_data",    32'(wr_data), 32'(k));
      check("sw_data_ready", 32'(hif.data_ready), 32'd0);
      tick();
    end
    check("sw_t9_wr_en",      32'(wr_en), 32'd0);
    check("sw_t9_data_ready", 32'(hif.data_ready), 32'd1);
    hif.abort = 1'b1;
    tick();
    hif.abort = 1'b0;
    check("sw_abort_busy", 32'(busy), 32'd0);
    check("sw_abort_idle", 32'(hif.cmd_ready), 32'd1);
    tick();

    // Full sprite 29, back-to-back words
    clear_model();
    send_cmd(SPR_IDW'(29));
    for (int i = 0; i < 128; i++) send_word(32'hA9A9_A9A9, 0);
    wait_done();
    check("full_done_wr_en", 32'(wr_en), 32'd0);
    check("full_done_busy",  32'(busy), 32'd1);
    check("full_last_addr",  32'(last_addr), 32'd1023);
    check("full_last_data",  32'(last_data), 32'hA);
    check("full_writes",     32'(nwrites), 32'd1024);
    tick();
    check("full_done_clr",   32'(done), 32'd0);
    check("full_busy_clr",   32'(busy), 32'd0);
    check("full_done_count", 32'(ndone), 32'd1);
    check("full_dup",        32'(ndup), 32'd0);
    raddr = SPR_ADDRW'(1023);
    tick();
    check("ram_1023", 32'(rdata), 32'hA);
    raddr = SPR_ADDRW'(0);
    tick();
    check("ram_0", 32'(rdata), 32'h9);

    // Full sprite 31 with random stalls; word i carries nibble i[3:0] in every pixel
    clear_model();
    send_cmd(SPR_IDW'(31));
    for (int i = 0; i < 128; i++) send_word({8{4'(i)}}, int'($urandom_range(0, 20)));
    wait_done();
    check("stall_writes", 32'(nwrites), 32'd1024);
    check("stall_dup",    32'(ndup), 32'd0);
    check("stall_nbad",   32'(nbad), 32'd0);
    bad = 0;
    for (int a = 0; a < int'(SPR_DEPTH); a++)
      if (!seen[a] || model[a] !== 4'((a >> 3) & 15)) bad++;
    check("stall_contents", 32'(bad), 32'd0);
    tick();
    check("stall_done_count", 32'(ndone), 32'd1);
    check("stall_idle",       32'(hif.cmd_ready), 32'd1);

    // Abort during nibble 3 of word 5
    clear_model();
    send_cmd(SPR_IDW'(30));
    for (int i = 0; i < 5; i++) send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    tick(); tick(); tick();
    check("abort_nib3_addr", 32'(wr_addr), 32'd43);
    check("abort_nib3_en",   32'(wr_en), 32'd1);
    hif.abort = 1'b1;
    tick();
    hif.abort = 1'b0;
    check("abort_wr_en",   32'(wr_en), 32'd0);
    check("abort_busy",    32'(busy), 32'd0);
    check("abort_idle",    32'(hif.cmd_ready), 32'd1);
    tick(); tick(); tick();
    check("abort_writes",  32'(nwrites), 32'd44);
    check("abort_no_done", 32'(ndone), 32'd0);

    // Restart at address 0, then reset at nibble 3
    clear_model();
    send_cmd(SPR_IDW'(30));
    send_word(32'h7654_3210, 0);
    check("restart_addr",   32'(wr_addr), 32'd0);
    check("restart_sprite", 32'(wr_sprite), 32'd30);
    tick(); tick(); tick();
    check("rreset_nib3_data", 32'(wr_data), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rreset_sprite", 32'(wr_sprite), 32'd0);
    check("rreset_wr_en",  32'(wr_en), 32'd0);
    check("rreset_busy",   32'(busy), 32'd0);
    check("rreset_idle",   32'(hif.cmd_ready), 32'd1);
    tick(); tick();
    check("rreset_writes", 32'(nwrites), 32'd4);
    check("rreset_done",   32'(ndone), 32'd0);

    // Rejected command with index 0
    clear_model();
    hif.cmd_valid  = 1'b1;
    hif.cmd_sprite = SPR_NONE;
    check("rej_ready", 32'(hif.cmd_ready), 32'd1);
    tick();
    hif.cmd_valid = 1'b0;
    check("rej_err",   32'(err), 32'd1);
    check("rej_busy",  32'(busy), 32'd0);
    check("rej_idle",  32'(hif.cmd_ready), 32'd1);
    tick();
    check("rej_err_clr", 32'(err), 32'd0);
    check("rej_writes",  32'(nwrites), 32'd0);

    // Command offered during UNPACK is held off until IDLE
    send_cmd(SPR_IDW'(28));
    send_word(32'h7654_3210, 0);
    hif.cmd_valid  = 1'b1;
    hif.cmd_sprite = SPR_IDW'(27);
    check("ovl_ready", 32'(hif.cmd_ready), 32'd0);
    tick();
    check("ovl_sprite_hold", 32'(wr_sprite), 32'd28);
    hif.abort = 1'b1;
    tick();
    hif.abort = 1'b0;
    check("ovl_idle_ready", 32'(hif.cmd_ready), 32'd1);
    check("ovl_sprite_idle", 32'(wr_sprite), 32'd28);
    tick();
    hif.cmd_valid = 1'b0;
    check("ovl_sprite_new", 32'(wr_sprite), 32'd27);
    check("ovl_busy",       32'(busy), 32'd1);
    hif.abort = 1'b1;
    tick();
    hif.abort = 1'b0;
    check("ovl_end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
